fir_seq_ctrl: RTL and testbench

//  Sequencer/configurator for the 3-tap free-running fir_filter datapath (no reset, no enable).

---
 rtl/fir_seq_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_fir_seq_ctrl.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_seq_ctrl.sv
// Sequencer/configurator for a free-running 3-tap fir_filter: history flush after reset,
// shadow/commit weight loading, framed sample feeding with zero flush slots and output tagging.
module fir_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [WIDTH-1:0]   cfg_wdata,
  input  logic               cfg_commit,
  input  logic               start,
  input  logic [LEN_W-1:0]   frame_len,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  output logic [WIDTH-1:0]   fir_in,
  output logic [WIDTH-1:0]   w_1,
  output logic [WIDTH-1:0]   w_2,
  output logic [WIDTH-1:0]   w_3,
  input  logic [2*WIDTH-1:0] fir_out,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] out_data,
  output logic               out_last,
  output logic               busy,
  output logic               underrun,
  output logic [1:0]         dbg_state
);

  // Handshake: a sample is taken on every posedge where in_ready (RUN) is high; in_valid low
  // in RUN still consumes the slot (zero fed, underrun flagged). There is no output backpressure.
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [WIDTH-1:0]   fir_in_q, fir_in_d;
  logic [WIDTH-1:0]   w1_q, w1_d, w2_q, w2_d, w3_q, w3_d;
  logic [WIDTH-1:0]   sh1_q, sh1_d, sh2_q, sh2_d, sh3_q, sh3_d;
  logic               pend_q, pend_d;
  logic               underrun_q, underrun_d;
  logic               v0_q, v0_d, v1_q, v2_q;
  logic               l0_q, l0_d, l1_q, l2_q;
  logic               start_go;
  logic               commit_apply;
  logic               is_idle;

  assign is_idle = (state_q == ST_IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    fir_in_d   = '0;
    underrun_d = underrun_q;
    v0_d       = 1'b0;
    l0_d       = 1'b0;
    start_go   = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == LEN_W'(2)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      ST_IDLE: begin
        if (start && (frame_len != '0)) begin
          start_go   = 1'b1;
          len_d      = frame_len;
          cnt_d      = '0;
          underrun_d = 1'b0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        fir_in_d = in_valid ? in_data : '0;
        v0_d     = 1'b1;
        if (!in_valid) begin
          underrun_d = 1'b1;
        end
        if (cnt_q == (len_q - LEN_W'(1))) begin
          cnt_d   = '0;
          state_d = ST_FLUSH;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      ST_FLUSH: begin
        v0_d = 1'b1;
        if (cnt_q == LEN_W'(1)) begin
          l0_d    = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_INIT;
      end
    endcase
  end

  // Shadow writes land at the edge, so a commit in the same cycle copies the old shadow value.
  always_comb begin
    sh1_d = sh1_q;
    sh2_d = sh2_q;
    sh3_d = sh3_q;
    if (cfg_we) begin
      case (cfg_addr)
        2'd0:    sh1_d = cfg_wdata;
        2'd1:    sh2_d = cfg_wdata;
        2'd2:    sh3_d = cfg_wdata;
        default: ;
      endcase
    end
  end

  // A pending commit is applied in the first IDLE cycle even if a frame starts in that cycle;
  // a fresh commit arriving together with an accepted start is deferred to after that frame.
  always_comb begin
    commit_apply = is_idle && (pend_q || (cfg_commit && !start_go));
    w1_d   = commit_apply ? sh1_q : w1_q;
    w2_d   = commit_apply ? sh2_q : w2_q;
    w3_d   = commit_apply ? sh3_q : w3_q;
    pend_d = pend_q;
    if (commit_apply) begin
      pend_d = 1'b0;
    end
    if (cfg_commit && !(is_idle && !start_go)) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      len_q      <= '0;
      fir_in_q   <= '0;
      w1_q       <= '0;
      w2_q       <= '0;
      w3_q       <= '0;
      sh1_q      <= '0;
      sh2_q      <= '0;
      sh3_q      <= '0;
      pend_q     <= 1'b0;
      underrun_q <= 1'b0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      l0_q       <= 1'b0;
      l1_q       <= 1'b0;
      l2_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      fir_in_q   <= fir_in_d;
      w1_q       <= w1_d;
      w2_q       <= w2_d;
      w3_q       <= w3_d;
      sh1_q      <= sh1_d;
      sh2_q      <= sh2_d;
      sh3_q      <= sh3_d;
      pend_q     <= pend_d;
      underrun_q <= underrun_d;
      v0_q       <= v0_d;
      v1_q       <= v0_q;
      v2_q       <= v1_q;
      l0_q       <= l0_d;
      l1_q       <= l0_q;
      l2_q       <= l1_q;
    end
  end

  // Tags trail fir_in by the filter's two-stage latency and keep draining after IDLE.
  assign in_ready  = (state_q == ST_RUN);
  assign busy      = !is_idle;
  assign fir_in    = fir_in_q;
  assign w_1       = w1_q;
  assign w_2       = w2_q;
  assign w_3       = w3_q;
  assign out_valid = v2_q;
  assign out_last  = l2_q;
  assign out_data  = fir_out;
  assign underrun  = underrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl with a behavioural 3-tap filter (registered input,
// transposed taps) closing the loop from fir_in/w_* back to fir_out.
module tb_fir_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic        cfg_commit;
  logic        start;
  logic [7:0]  frame_len;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [7:0]  fir_in;
  logic [7:0]  w_1, w_2, w_3;
  logic [15:0] fir_out;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        underrun;
  logic [1:0]  dbg_state;

  int          total;
  int          bad;
  int          cyc;
  int          accept_cyc;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic        got_last_q[$];
  int          got_cyc_q[$];
  logic [15:0] d;
  logic        l;
  bit          ok;

  fir_seq_ctrl #(.WIDTH(8), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_commit(cfg_commit), .start(start), .frame_len(frame_len), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .fir_in(fir_in), .w_1(w_1), .w_2(w_2), .w_3(w_3),
    .fir_out(fir_out), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .busy(busy), .underrun(underrun), .dbg_state(dbg_state)
  );

  // clock / reset-independent infrastructure
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // filter model: y[n] = w1*x[n] + w2*x[n-1] + w3*x[n-2], two cycles after fir_in
  logic [7:0]  x_reg;
  logic [15:0] f1, f2, f3;
  always @(posedge clk) begin
    x_reg <= fir_in;
    f3    <= 16'(w_3) * 16'(x_reg);
    f2    <= 16'(w_2) * 16'(x_reg) + f3;
    f1    <= 16'(w_1) * 16'(x_reg) + f2;
  end
  assign fir_out = f1;

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      got_q.push_back(out_data);
      got_last_q.push_back(out_last);
      got_cyc_q.push_back(cyc);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] v);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = v;
    tick();
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'd0;
  endtask

  task automatic commit_pulse();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic load_weights(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    cfg_write(2'd0, a);
    cfg_write(2'd1, b);
    cfg_write(2'd2, c);
    commit_pulse();
  endtask

  task automatic start_pulse(input logic [7:0] len);
    start = 1'b1; frame_len = len;
    tick();
    start = 1'b0; frame_len = 8'd0;
  endtask

  // slot i feeds xs[8i+:8] with valid vm[i]; optional commit / stray start in one slot
  task automatic run_slots(input int n, input logic [31:0] xs, input logic [3:0] vm,
                           input int commit_slot, input int start_slot);
    for (int i = 0; i < n; i++) begin
      in_valid   = vm[i];
      in_data    = xs[8*i +: 8];
      cfg_commit = (i == commit_slot);
      if (i == start_slot) begin
        start = 1'b1; frame_len = 8'd1;
      end
      tick();
      if (i == 0) accept_cyc = cyc;
      in_valid = 1'b0; in_data = 8'd0; cfg_commit = 1'b0; start = 1'b0; frame_len = 8'd0;
    end
  endtask

  task automatic wait_outs(input int n, output bit done);
    int k = 0;
    while (got_q.size() < n && k < 60) begin
      tick();
      k++;
    end
    repeat (6) tick();
    done = (got_q.size() >= n);
  endtask

  task automatic clear_got();
    got_q.delete();
    got_last_q.delete();
    got_cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || fir_in !== 8'd0 ||
        w_1 !== 8'd0 || underrun !== 1'b0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL reset_vals busy=%b rdy=%b ov=%b fir_in=%0d w1=%0d ur=%b st=%0d want 1 0 0 0 0 0 0",
               busy, in_ready, out_valid, fir_in, w_1, underrun, dbg_state);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (busy !== (i < 2) || out_valid !== 1'b0 || fir_in !== 8'd0) begin
        bad++;
        $display("FAIL init_seq%0d busy=%b ov=%b fir_in=%0d want busy=%b ov=0 fir_in=0",
                 i, busy, out_valid, fir_in, (i < 2));
      end
    end
    total++;
    if (got_q.size() != 0) begin
      bad++;
      $display("FAIL init_no_out got=%0d want=0", got_q.size());
    end
    clear_got();
  endtask

  task automatic test_main();
    load_weights(8'd1, 8'd2, 8'd3);
    total++;
    if (w_1 !== 8'd1 || w_2 !== 8'd2 || w_3 !== 8'd3) begin
      bad++;
      $display("FAIL main_weights got=%0d,%0d,%0d want=1,2,3", w_1, w_2, w_3);
    end
    start_pulse(8'd3);
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL main_ready rdy=%b busy=%b want 1 1", in_ready, busy);
    end
    run_slots(3, 32'h00030201, 4'b0111, -1, -1);
    exp_q = '{16'd1, 16'd4, 16'd10, 16'd12, 16'd9};
    wait_outs(5, ok);
    total++;
    if (!ok || got_q.size() != 5) begin
      bad++;
      $display("FAIL main_count got=%0d want=5", got_q.size());
    end
    total++;
    if (got_cyc_q.size() == 0 || got_cyc_q[0] != accept_cyc + 2) begin
      bad++;
      $display("FAIL main_latency got=%0d want=%0d", (got_cyc_q.size() == 0) ? -1 : got_cyc_q[0], accept_cyc + 2);
    end
    for (int i = 0; i < 5; i++) begin
      if (got_q.size() == 0) break;
      d = got_q.pop_front(); l = got_last_q.pop_front();
      total++;
      if (d !== exp_q[i] || l !== (i == 4)) begin
        bad++;
        $display("FAIL main_out%0d data=%0d last=%b want data=%0d last=%b", i, d, l, exp_q[i], (i == 4));
      end
    end
    total++;
    if (underrun !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL main_end underrun=%b busy=%b want 0 0", underrun, busy);
    end
    clear_got();
  endtask

  task automatic test_underrun();
    start_pulse(8'd3);
    run_slots(3, 32'h00030201, 4'b0101, -1, -1);
    exp_q = '{16'd1, 16'd2, 16'd6, 16'd6, 16'd9};
    wait_outs(5, ok);
    total++;
    if (!ok || got_q.size() != 5 || underrun !== 1'b1) begin
      bad++;
      $display("FAIL underrun_count got=%0d ur=%b want=5 ur=1", got_q.size(), underrun);
    end
    for (int i = 0; i < 5; i++) begin
      if (got_q.size() == 0) break;
      d = got_q.pop_front(); l = got_last_q.pop_front();
      total++;
      if (d !== exp_q[i] || l !== (i == 4)) begin
        bad++;
        $display("FAIL underrun_out%0d data=%0d last=%b want data=%0d last=%b", i, d, l, exp_q[i], (i == 4));
      end
    end
    clear_got();
  endtask

  task automatic test_commit_mid_frame();
    cfg_write(2'd0, 8'd2);
    cfg_write(2'd1, 8'd0);
    cfg_write(2'd2, 8'd0);
    total++;
    if (w_1 !== 8'd1 || w_2 !== 8'd2) begin
      bad++;
      $display("FAIL shadow_leak w1=%0d w2=%0d want 1 2", w_1, w_2);
    end
    start_pulse(8'd3);
    total++;
    if (underrun !== 1'b0) begin
      bad++;
      $display("FAIL underrun_clear got=%b want=0", underrun);
    end
    run_slots(3, 32'h00030201, 4'b0111, 1, -1);
    total++;
    if (w_1 !== 8'd1 || w_2 !== 8'd2 || w_3 !== 8'd3) begin
      bad++;
      $display("FAIL commit_busy got=%0d,%0d,%0d want=1,2,3", w_1, w_2, w_3);
    end
    exp_q = '{16'd1, 16'd4, 16'd10, 16'd12, 16'd9};
    wait_outs(5, ok);
    total++;
    if (!ok || got_q.size() != 5 || w_1 !== 8'd2 || w_2 !== 8'd0 || w_3 !== 8'd0) begin
      bad++;
      $display("FAIL commit_pend cnt=%0d w=%0d,%0d,%0d want cnt=5 w=2,0,0", got_q.size(), w_1, w_2, w_3);
    end
    for (int i = 0; i < 5; i++) begin
      if (got_q.size() == 0) break;
      d = got_q.pop_front(); l = got_last_q.pop_front();
      total++;
      if (d !== exp_q[i] || l !== (i == 4)) begin
        bad++;
        $display("FAIL commit_f1_out%0d data=%0d last=%b want data=%0d last=%b", i, d, l, exp_q[i], (i == 4));
      end
    end
    clear_got();
    start_pulse(8'd1);
    run_slots(1, 32'h00000005, 4'b0001, -1, -1);
    exp_q = '{16'd10, 16'd0, 16'd0};
    wait_outs(3, ok);
    total++;
    if (!ok || got_q.size() != 3) begin
      bad++;
      $display("FAIL commit_f2_count got=%0d want=3", got_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (got_q.size() == 0) break;
      d = got_q.pop_front(); l = got_last_q.pop_front();
      total++;
      if (d !== exp_q[i] || l !== (i == 2)) begin
        bad++;
        $display("FAIL commit_f2_out%0d data=%0d last=%b want data=%0d last=%b", i, d, l, exp_q[i], (i == 2));
      end
    end
    clear_got();
  endtask

  task automatic test_cfg_edges();
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 8'd7; cfg_commit = 1'b1;
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    tick();
    total++;
    if (w_1 !== 8'd2) begin
      bad++;
      $display("FAIL we_commit_same got=%0d want=2", w_1);
    end
    commit_pulse();
    tick();
    total++;
    if (w_1 !== 8'd7) begin
      bad++;
      $display("FAIL later_commit got=%0d want=7", w_1);
    end
    cfg_write(2'd3, 8'd9);
    commit_pulse();
    tick();
    total++;
    if (w_1 !== 8'd7 || w_2 !== 8'd0 || w_3 !== 8'd0) begin
      bad++;
      $display("FAIL addr3_drop got=%0d,%0d,%0d want=7,0,0", w_1, w_2, w_3);
    end
  endtask

  task automatic test_ignored_start();
    start_pulse(8'd0);
    repeat (4) tick();
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || got_q.size() != 0) begin
      bad++;
      $display("FAIL len0_start busy=%b rdy=%b outs=%0d want 0 0 0", busy, in_ready, got_q.size());
    end
    start_pulse(8'd2);
    run_slots(2, 32'h00000201, 4'b0011, -1, 0);
    exp_q = '{16'd7, 16'd14, 16'd0, 16'd0};
    wait_outs(4, ok);
    total++;
    if (!ok || got_q.size() != 4 || busy !== 1'b0) begin
      bad++;
      $display("FAIL run_start_count got=%0d busy=%b want=4 busy=0", got_q.size(), busy);
    end
    for (int i = 0; i < 4; i++) begin
      if (got_q.size() == 0) break;
      d = got_q.pop_front(); l = got_last_q.pop_front();
      total++;
      if (d !== exp_q[i] || l !== (i == 3)) begin
        bad++;
        $display("FAIL run_start_out%0d data=%0d last=%b want data=%0d last=%b", i, d, l, exp_q[i], (i == 3));
      end
    end
    clear_got();
  endtask

  task automatic test_reset_mid_frame();
    start_pulse(8'd3);
    run_slots(1, 32'h00000001, 4'b0001, -1, -1);
    in_valid = 1'b1; in_data = 8'd2;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || w_1 !== 8'd0 || busy !== 1'b1 || fir_in !== 8'd0) begin
      bad++;
      $display("FAIL abort_now rdy=%b ov=%b w1=%0d busy=%b fir_in=%0d want 0 0 0 1 0",
               in_ready, out_valid, w_1, busy, fir_in);
    end
    in_valid = 1'b0; in_data = 8'd0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (busy !== (i < 2)) begin
        bad++;
        $display("FAIL reinit%0d busy=%b want=%b", i, busy, (i < 2));
      end
    end
    repeat (8) tick();
    total++;
    if (got_q.size() != 0) begin
      bad++;
      $display("FAIL abort_no_out got=%0d want=0", got_q.size());
    end
    clear_got();
    load_weights(8'd1, 8'd2, 8'd3);
    start_pulse(8'd1);
    run_slots(1, 32'h00000004, 4'b0001, -1, -1);
    exp_q = '{16'd4, 16'd8, 16'd12};
    wait_outs(3, ok);
    total++;
    if (!ok || got_q.size() != 3) begin
      bad++;
      $display("FAIL post_reset_count got=%0d want=3", got_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (got_q.size() == 0) break;
      d = got_q.pop_front(); l = got_last_q.pop_front();
      total++;
      if (d !== exp_q[i] || l !== (i == 2)) begin
        bad++;
        $display("FAIL post_reset_out%0d data=%0d last=%b want data=%0d last=%b", i, d, l, exp_q[i], (i == 2));
      end
    end
    clear_got();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; accept_cyc = 0;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'd0; cfg_commit = 1'b0;
    start = 1'b0; frame_len = 8'd0; in_valid = 1'b0; in_data = 8'd0;
    test_reset();
    test_main();
    test_underrun();
    test_commit_mid_frame();
    test_cfg_edges();
    test_ignored_start();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
